sram_ctrl: RTL and testbench

- Clocked controller between the SoC native memory bus (valid/ready, 32-bit, byte strobes) and an external asynchronous SRAM with active-low byte enables.
- Parametrised successor to the fixed 64Kx16 SRAM part:
  - SRAM data width of 16 or 32 bits.
  - Configurable address width.
  - Programmable wait states.
  - Automatic split of a 32-bit bus word into two SRAM accesses when the SRAM is 16 bits wide.
- The tri-state data pad sits at top level; this block drives sram_dout and sram_d_oe and samples sram_din.

---
 rtl/sram_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges the native memory bus (valid/ready, 32-bit, byte strobes)
// to an external asynchronous SRAM with active-low byte enables.
//
// Parameters:
//   ADDR_WIDTH  - SRAM word-address bits
//   DATA_WIDTH  - SRAM data width, 16 or 32 (16 splits each bus word in two halves)
//   WAIT_STATES - extra cycles per read access or write pulse, 0..15
//
// Ports:
//   clk, resetn                      - system clock, async active-low reset
//   mem_valid/addr/wdata/wstrb       - bus request (wstrb == 0 means read)
//   mem_ready/mem_rdata              - one-cycle completion pulse and read data
//   sram_addr/dout/din/d_oe          - SRAM address and data; pad tri-state lives above
//   sram_ce_n/oe_n/we_n/be_n         - SRAM strobes, active low
//
// Build option: define SRAM_CTRL_RDCACHE_EN to add a one-entry read buffer.
// A hit answers in one cycle without touching the SRAM; a write to the
// buffered word invalidates it.

module sram_ctrl #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      mem_valid,
   input  logic [31:0]               mem_addr,
   input  logic [31:0]               mem_wdata,
   input  logic [3:0]                mem_wstrb,
   output logic                      mem_ready,
   output logic [31:0]               mem_rdata,
   output logic [ADDR_WIDTH-1:0]     sram_addr,
   output logic [DATA_WIDTH-1:0]     sram_dout,
   input  logic [DATA_WIDTH-1:0]     sram_din,
   output logic                      sram_d_oe,
   output logic                      sram_ce_n,
   output logic                      sram_oe_n,
   output logic                      sram_we_n,
   output logic [DATA_WIDTH/8-1:0]   sram_be_n
);

   // state    | meaning
   // IDLE     | waiting for mem_valid; SRAM deselected
   // RD       | read access of the current half, 1+WAIT_STATES cycles
   // WR_SETUP | address/data/byte enables set up, we_n still high
   // WR_PULSE | write pulse, we_n low for 1+WAIT_STATES cycles
   // WR_HOLD  | we_n released, address and data held one more cycle
   // DONE     | mem_ready pulse, SRAM deselected

   localparam int         BE_W      = DATA_WIDTH / 8;
   localparam bit         HALF_MODE = (DATA_WIDTH == 16);
   // Latched word address excludes the half-select bit in 16-bit mode.
   localparam int         WA_W      = HALF_MODE ? ADDR_WIDTH - 1 : ADDR_WIDTH;
   localparam logic [3:0] WS_LOAD   = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WA_W-1:0]   waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              half_q,  half_d;
   logic [3:0]        wait_q,  wait_d;
   logic [31:0]       rdata_q, rdata_d;

`ifdef SRAM_CTRL_RDCACHE_EN
   logic [WA_W-1:0]   tag_q,    tag_d;
   logic [31:0]       cdata_q,  cdata_d;
   logic              cvalid_q, cvalid_d;
`endif

   logic [WA_W-1:0]       req_waddr;
   logic [DATA_WIDTH-1:0] wr_slice;
   logic [BE_W-1:0]       strb_slice;
   logic [31:0]           rdata_cap;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic                  rd_last;
   logic                  wr_more;
   logic                  wr_first;
   logic                  unused_addr;

   assign req_waddr   = mem_addr[WA_W+1:2];
   assign unused_addr = ^{mem_addr[31:WA_W+2], mem_addr[1:0]};

   generate
      if (HALF_MODE) begin : g_half
         assign wr_slice   = half_q ? wdata_q[31:16] : wdata_q[15:0];
         assign strb_slice = half_q ? wstrb_q[3:2]   : wstrb_q[1:0];
         assign rdata_cap  = half_q ? {sram_din, rdata_q[15:0]}
                                    : {rdata_q[31:16], sram_din};
         assign addr_out   = {waddr_q, half_q};
         assign rd_last    = half_q;
         assign wr_more    = ~half_q & (|wstrb_q[3:2]);
         // A write with no low-half strobes starts directly on the high half.
         assign wr_first   = ~(|mem_wstrb[1:0]);
      end else begin : g_full
         logic unused_half;
         assign unused_half = half_q;
         assign wr_slice    = wdata_q;
         assign strb_slice  = wstrb_q;
         assign rdata_cap   = sram_din;
         assign addr_out    = waddr_q;
         assign rd_last     = 1'b1;
         assign wr_more     = 1'b0;
         assign wr_first    = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         half_q   <= 1'b0;
         wait_q   <= '0;
         rdata_q  <= '0;
`ifdef SRAM_CTRL_RDCACHE_EN
         tag_q    <= '0;
         cdata_q  <= '0;
         cvalid_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         half_q   <= half_d;
         wait_q   <= wait_d;
         rdata_q  <= rdata_d;
`ifdef SRAM_CTRL_RDCACHE_EN
         tag_q    <= tag_d;
         cdata_q  <= cdata_d;
         cvalid_q <= cvalid_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      half_d   = half_q;
      wait_d   = wait_q;
      rdata_d  = rdata_q;
`ifdef SRAM_CTRL_RDCACHE_EN
      tag_d    = tag_q;
      cdata_d  = cdata_q;
      cvalid_d = cvalid_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_valid) begin
               waddr_d = req_waddr;
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               half_d  = 1'b0;
               if (mem_wstrb == 4'b0000) begin
`ifdef SRAM_CTRL_RDCACHE_EN
                  if (cvalid_q && (tag_q == req_waddr)) begin
                     rdata_d = cdata_q;
                     state_d = DONE;
                  end else begin
                     wait_d  = WS_LOAD;
                     state_d = RD;
                  end
`else
                  wait_d  = WS_LOAD;
                  state_d = RD;
`endif
               end else begin
                  half_d  = wr_first;
                  state_d = WR_SETUP;
`ifdef SRAM_CTRL_RDCACHE_EN
                  if (tag_q == req_waddr) begin
                     cvalid_d = 1'b0;
                  end
`endif
               end
            end
         end
         RD: begin
            if (wait_q == 4'd0) begin
               rdata_d = rdata_cap;
               if (rd_last) begin
                  state_d = DONE;
               end else begin
                  half_d = 1'b1;
                  wait_d = WS_LOAD;
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         WR_SETUP: begin
            wait_d  = WS_LOAD;
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (wait_q == 4'd0) begin
               state_d = WR_HOLD;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         WR_HOLD: begin
            if (wr_more) begin
               half_d  = 1'b1;
               state_d = WR_SETUP;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef SRAM_CTRL_RDCACHE_EN
            // Refilling after a hit rewrites identical contents, so no need
            // to distinguish hit from miss here.
            if (wstrb_q == 4'b0000) begin
               tag_d    = waddr_q;
               cdata_d  = rdata_q;
               cvalid_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM strobes decode straight from the state register so that an async
   // reset deselects the part without waiting for a clock.
   always_comb begin
      sram_ce_n = 1'b1;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
      sram_be_n = '1;
      sram_d_oe = 1'b0;
      case (state_q)
         RD: begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
            sram_be_n = '0;
         end
         WR_SETUP, WR_HOLD: begin
            sram_ce_n = 1'b0;
            sram_d_oe = 1'b1;
            sram_be_n = ~strb_slice;
         end
         WR_PULSE: begin
            sram_ce_n = 1'b0;
            sram_we_n = 1'b0;
            sram_d_oe = 1'b1;
            sram_be_n = ~strb_slice;
         end
         default: ;
      endcase
   end

   assign sram_addr = addr_out;
   assign sram_dout = wr_slice;
   assign mem_rdata = rdata_q;
   assign mem_ready = (state_q == DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns/1ps
module tb_sram_ctrl;

   localparam int AW = 10;
`ifdef SRAM_CTRL_RDCACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] rdata;
      int          n;
      bit          is_rd;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        valid = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        sel   = 1'b0;
   logic        mem_clr = 1'b1;

   // instance A: 16-bit SRAM, one wait state
   logic          a_ready, a_doe, a_ce_n, a_oe_n, a_we_n;
   logic [31:0]   a_rdata;
   logic [AW-1:0] a_addr;
   logic [15:0]   a_dout, a_din;
   logic [1:0]    a_be_n;
   // instance B: 32-bit SRAM, no wait states
   logic          b_ready, b_doe, b_ce_n, b_oe_n, b_we_n;
   logic [31:0]   b_rdata;
   logic [AW-1:0] b_addr;
   logic [31:0]   b_dout, b_din;
   logic [3:0]    b_be_n;

   sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .WAIT_STATES(1)) u_a (
      .clk(clk), .resetn(resetn), .mem_valid(valid & ~sel), .mem_addr(addr),
      .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(a_ready), .mem_rdata(a_rdata),
      .sram_addr(a_addr), .sram_dout(a_dout), .sram_din(a_din), .sram_d_oe(a_doe),
      .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_be_n(a_be_n));

   sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(0)) u_b (
      .clk(clk), .resetn(resetn), .mem_valid(valid & sel), .mem_addr(addr),
      .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(b_ready), .mem_rdata(b_rdata),
      .sram_addr(b_addr), .sram_dout(b_dout), .sram_din(b_din), .sram_d_oe(b_doe),
      .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n));

   // behavioural asynchronous SRAMs
   logic [15:0] mem16 [0:1023];
   logic [31:0] mem32 [0:1023];

   assign a_din = (!a_ce_n && !a_oe_n) ? mem16[a_addr] : 16'h0000;
   assign b_din = (!b_ce_n && !b_oe_n) ? mem32[b_addr] : 32'h0;

   always @(negedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) begin
            mem16[i] <= '0;
            mem32[i] <= '0;
         end
      end else begin
         if (!a_ce_n && !a_we_n) begin
            if (!a_be_n[0]) mem16[a_addr][7:0]  <= a_dout[7:0];
            if (!a_be_n[1]) mem16[a_addr][15:8] <= a_dout[15:8];
         end
         if (!b_ce_n && !b_we_n) begin
            if (!b_be_n[0]) mem32[b_addr][7:0]   <= b_dout[7:0];
            if (!b_be_n[1]) mem32[b_addr][15:8]  <= b_dout[15:8];
            if (!b_be_n[2]) mem32[b_addr][23:16] <= b_dout[23:16];
            if (!b_be_n[3]) mem32[b_addr][31:24] <= b_dout[31:24];
         end
      end
   end

   // view of the selected instance
   logic        v_ready, v_ce_n, v_oe_n, v_we_n, v_doe;
   logic [31:0] v_rdata, v_addr;
   logic [3:0]  v_be_n;
   assign v_ready = sel ? b_ready : a_ready;
   assign v_ce_n  = sel ? b_ce_n  : a_ce_n;
   assign v_oe_n  = sel ? b_oe_n  : a_oe_n;
   assign v_we_n  = sel ? b_we_n  : a_we_n;
   assign v_doe   = sel ? b_doe   : a_doe;
   assign v_rdata = sel ? b_rdata : a_rdata;
   assign v_addr  = sel ? 32'(b_addr) : 32'(a_addr);
   assign v_be_n  = sel ? b_be_n  : {2'b11, a_be_n};

   int          n_lat, we_low, ce_low, oe_low, doe_high;
   logic [3:0]  be_seen;
   logic [31:0] addr_first, addr_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string name, input logic s, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, input int exp_n);
      exp_t e;
      bit   got;
      bit   first;
      e.rdata = exp_rd;
      e.n     = exp_n;
      e.is_rd = (st == 4'b0000);
      sb.push_back(e);
      @(negedge clk);
      sel = s; addr = ad; wdata = wd; wstrb = st; valid = 1'b1;
      @(posedge clk);
      n_lat = 0; we_low = 0; ce_low = 0; oe_low = 0; doe_high = 0;
      be_seen = 4'hf; addr_first = '0; addr_last = '0;
      got = 1'b0; first = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         if (!v_ce_n) begin
            ce_low++;
            be_seen = v_be_n;
            if (!first) addr_first = v_addr;
            addr_last = v_addr;
            first = 1'b1;
         end
         if (!v_we_n) we_low++;
         if (!v_oe_n) oe_low++;
         if (v_doe)   doe_high++;
         if (v_ready) begin
            got   = 1'b1;
            n_lat = k + 1;
         end else begin
            @(posedge clk);
         end
      end
      valid = 1'b0;
      e = sb.pop_front();
      chk({name, ".ready_seen"}, 32'(got), 32'd1);
      chk({name, ".latency"}, 32'(n_lat), 32'(e.n));
      if (e.is_rd) chk({name, ".rdata"}, v_rdata, e.rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst.a_ce_n", 32'(a_ce_n), 32'd1);
      chk("rst.a_oe_n", 32'(a_oe_n), 32'd1);
      chk("rst.a_we_n", 32'(a_we_n), 32'd1);
      chk("rst.a_be_n", 32'(a_be_n), 32'h3);
      chk("rst.a_doe",  32'(a_doe),  32'd0);
      chk("rst.a_addr", 32'(a_addr), 32'd0);
      chk("rst.a_dout", 32'(a_dout), 32'd0);
      chk("rst.a_rdata", a_rdata, 32'd0);
      chk("rst.a_ready", 32'(a_ready), 32'd0);
      chk("rst.b_be_n", 32'(b_be_n), 32'hf);
      chk("rst.b_ce_n", 32'(b_ce_n), 32'd1);
      chk("rst.b_dout", b_dout, 32'd0);
      @(negedge clk);
      mem_clr = 1'b0;
      resetn  = 1'b1;

      // 16-bit SRAM, one wait state
      xfer("wr16", 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 9);
      chk("wr16.we_low", 32'(we_low), 32'd4);
      chk("wr16.ce_low", 32'(ce_low), 32'd8);
      chk("wr16.oe_low", 32'(oe_low), 32'd0);
      chk("wr16.addr_first", addr_first, 32'h080);
      chk("wr16.addr_last", addr_last, 32'h081);
      chk("wr16.mem_lo", 32'(mem16[10'h080]), 32'hBEEF);
      chk("wr16.mem_hi", 32'(mem16[10'h081]), 32'hDEAD);

      xfer("rd16", 1'b0, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF, 5);
      chk("rd16.oe_low", 32'(oe_low), 32'd4);
      chk("rd16.doe", 32'(doe_high), 32'd0);

      xfer("bytewr", 1'b0, 32'h100, 32'h00AA0000, 4'b0100, 32'h0, 5);
      chk("bytewr.be_n", 32'(be_seen), 32'hE);
      chk("bytewr.addr_first", addr_first, 32'h081);
      chk("bytewr.addr_last", addr_last, 32'h081);
      chk("bytewr.ce_low", 32'(ce_low), 32'd4);

      xfer("rd_after_byte", 1'b0, 32'h100, 32'h0, 4'b0000, 32'hDEAABEEF, 5);
      xfer("rd_again", 1'b0, 32'h100, 32'h0, 4'b0000, 32'hDEAABEEF, CACHE ? 1 : 5);
      chk("rd_again.ce_low", 32'(ce_low), CACHE ? 32'd0 : 32'd4);

      xfer("wr104", 1'b0, 32'h104, 32'h11112222, 4'b1111, 32'h0, 9);
      xfer("rd100_after_wr104", 1'b0, 32'h100, 32'h0, 4'b0000, 32'hDEAABEEF, CACHE ? 1 : 5);
      xfer("wr100_new", 1'b0, 32'h100, 32'hCAFEF00D, 4'b1111, 32'h0, 9);
      xfer("rd100_new", 1'b0, 32'h100, 32'h0, 4'b0000, 32'hCAFEF00D, 5);
      xfer("rd104", 1'b0, 32'h104, 32'h0, 4'b0000, 32'h11112222, 5);

      // 32-bit SRAM, no wait states
      xfer("wr32", 1'b1, 32'h40, 32'h12345678, 4'b1001, 32'h0, 4);
      chk("wr32.addr", addr_first, 32'h010);
      chk("wr32.be_n", 32'(be_seen), 32'h6);
      chk("wr32.we_low", 32'(we_low), 32'd1);
      chk("wr32.mem", mem32[10'h010], 32'h12000078);
      xfer("rd32", 1'b1, 32'h40, 32'h0, 4'b0000, 32'h12000078, 2);
      xfer("rd32_alias", 1'b1, 32'h1040, 32'h0, 4'b0000, 32'h12000078, CACHE ? 1 : 2);

      // reset in the middle of a write pulse
      @(negedge clk);
      sel = 1'b0; addr = 32'h200; wdata = 32'h77778888; wstrb = 4'b1111; valid = 1'b1;
      for (int k = 0; k < 20 && a_we_n; k++) @(negedge clk);
      chk("rst_mid.pulse_seen", 32'(a_we_n), 32'd0);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid.we_n", 32'(a_we_n), 32'd1);
      chk("rst_mid.ce_n", 32'(a_ce_n), 32'd1);
      chk("rst_mid.be_n", 32'(a_be_n), 32'h3);
      chk("rst_mid.doe",  32'(a_doe),  32'd0);
      chk("rst_mid.addr", 32'(a_addr), 32'd0);
      valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      xfer("rd_after_rst", 1'b0, 32'h100, 32'h0, 4'b0000, 32'hCAFEF00D, 5);
      chk("rd_after_rst.ce_low", 32'(ce_low), 32'd4);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
